// File: rtl/ir_cmd_ctrl.sv
// IR remote command controller: maps decoded NEC command bytes onto a queued
// snake direction, a pause toggle and a restart pulse. Optional IR_LOCKOUT_EN adds repeat-code lockout.
module ir_cmd_ctrl #(
  parameter logic [7:0]  CODE_UP      = 8'h18,
  parameter logic [7:0]  CODE_DOWN    = 8'h52,
  parameter logic [7:0]  CODE_LEFT    = 8'h08,
  parameter logic [7:0]  CODE_RIGHT   = 8'h5A,
  parameter logic [7:0]  CODE_PAUSE   = 8'h1C,
  parameter logic [7:0]  CODE_RESTART = 8'h16,
  parameter logic [22:0] LOCK_CYC     = 23'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_data,
  input  logic       ir_dout_vld,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       paused,
  output logic       restart,
  output logic       key_drop
);

  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic            dir_chg_q, dir_chg_d;
  logic            restart_q, restart_d;
  logic            key_drop_q, key_drop_d;
  logic [1:0][1:0] fifo_q, fifo_d;
  logic [1:0]      cnt_q, cnt_d;

  logic       is_dir, is_pause, is_rst, known;
  logic [1:0] cmd_dir, ref_dir, wr_idx;
  logic       vld_eff, pop, accept;

  always_comb begin
    is_dir   = 1'b1;
    cmd_dir  = 2'b00;
    is_pause = 1'b0;
    is_rst   = 1'b0;
    if      (ir_data == CODE_UP)    cmd_dir = 2'b00;
    else if (ir_data == CODE_DOWN)  cmd_dir = 2'b01;
    else if (ir_data == CODE_LEFT)  cmd_dir = 2'b10;
    else if (ir_data == CODE_RIGHT) cmd_dir = 2'b11;
    else begin
      is_dir   = 1'b0;
      is_pause = (ir_data == CODE_PAUSE);
      is_rst   = (ir_data == CODE_RESTART);
    end
    known = is_dir | is_pause | is_rst;
  end

`ifdef IR_LOCKOUT_EN
  logic [7:0]  last_q, last_d;
  logic [22:0] lock_q, lock_d;
  logic        locked;

  // A repeat of the last recognised code is swallowed while the counter runs.
  assign locked  = known && (lock_q != '0) && (ir_data == last_q);
  assign vld_eff = ir_dout_vld & ~locked;

  always_comb begin
    last_d = last_q;
    lock_d = lock_q;
    if (ir_dout_vld && known && !locked) begin
      last_d = ir_data;
      lock_d = LOCK_CYC;
    end else if (lock_q != '0) begin
      lock_d = lock_q - 23'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      lock_q <= '0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^LOCK_CYC;
  assign vld_eff     = ir_dout_vld;
`endif

  // New directions are judged against the last queued one, not the live one.
  assign ref_dir = (cnt_q == 2'd2) ? fifo_q[1] :
                   (cnt_q == 2'd1) ? fifo_q[0] : dir_q;
  assign pop     = tick && (state_q == RUN) && (cnt_q != 2'd0);
  assign accept  = vld_eff && is_dir && (state_q == RUN) && (cnt_q < 2'd2) &&
                   (cmd_dir != ref_dir) && (cmd_dir[1] != ref_dir[1]);
  assign wr_idx  = cnt_q - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    fifo_d     = fifo_q;
    cnt_d      = cnt_q;
    dir_chg_d  = 1'b0;
    restart_d  = 1'b0;
    key_drop_d = 1'b0;
    if (vld_eff && is_rst) begin
      restart_d = 1'b1;
      cnt_d     = 2'd0;
      dir_d     = 2'b11;
      state_d   = RUN;
    end else begin
      if (pop) begin
        dir_d     = fifo_q[0];
        dir_chg_d = 1'b1;
        fifo_d[0] = fifo_q[1];
      end
      if (accept) fifo_d[wr_idx[0]] = cmd_dir;
      cnt_d = cnt_q - {1'b0, pop} + {1'b0, accept};
      if (vld_eff && is_pause) state_d = (state_q == RUN) ? PAUSE : RUN;
      if (vld_eff && ((is_dir && !accept) || !known)) key_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      dir_q      <= 2'b11;
      fifo_q     <= '0;
      cnt_q      <= 2'd0;
      dir_chg_q  <= 1'b0;
      restart_q  <= 1'b0;
      key_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      fifo_q     <= fifo_d;
      cnt_q      <= cnt_d;
      dir_chg_q  <= dir_chg_d;
      restart_q  <= restart_d;
      key_drop_q <= key_drop_d;
    end
  end

  assign dir      = dir_q;
  assign dir_chg  = dir_chg_q;
  assign paused   = (state_q == PAUSE);
  assign restart  = restart_q;
  assign key_drop = key_drop_q;

endmodule
